// File: rtl/mac_mult_issue.sv
// mac_mult_issue: issues A/B reads in (i,j,k) order and emits one tagged registered product per cycle.
// Optional MAC_MULT_SIGNED_EN selects a two's-complement multiply instead of unsigned.
module mac_mult_issue #(
    parameter int M = 4,
    parameter int K = 4,
    parameter int N = 4,
    parameter int DATA_WIDTH_INIT_MATRIX = 32,
    localparam int MW = (M > 1) ? $clog2(M) : 1,
    localparam int KW = (K > 1) ? $clog2(K) : 1,
    localparam int NW = (N > 1) ? $clog2(N) : 1,
    localparam int DW = DATA_WIDTH_INIT_MATRIX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            mem_rd_en,
    output logic [MW-1:0]   addr_a_row,
    output logic [KW-1:0]   addr_a_col,
    output logic [KW-1:0]   addr_b_row,
    output logic [NW-1:0]   addr_b_col,
    input  logic [DW-1:0]   data_in_a,
    input  logic [DW-1:0]   data_in_b,
    output logic [2*DW-1:0] product_reg,
    output logic [MW-1:0]   matrix_a_row_addr_counter_reg,
    output logic [NW-1:0]   matrix_b_col_addr_counter_reg,
    output logic [KW-1:0]   matrix_a_col_addr_counter_reg,
    output logic [KW-1:0]   matrix_b_row_addr_counter_reg,
    output logic            mult_done_reg
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [MW-1:0] I_LAST = MW'(M - 1);
    localparam logic [NW-1:0] J_LAST = NW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    state_t state_q, state_d;
    logic [MW-1:0] i_q, i_d;
    logic [NW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic drain_q, drain_d;
    logic v1_q;
    logic [MW-1:0] ti_q;
    logic [NW-1:0] tj_q;
    logic [KW-1:0] tk_q;
    logic [2*DW-1:0] product_d;
    logic k_wrap, j_wrap, last;
    assign k_wrap = k_q == K_LAST;
    assign j_wrap = k_wrap && j_q == J_LAST;
    assign last = j_wrap && i_q == I_LAST;
    always_comb begin
        state_d = state_q;
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                i_d = '0;
                j_d = '0;
                k_d = '0;
            end
            ISSUE: if (last) begin
                state_d = DRAIN;
                drain_d = 1'b0;
            end else begin
                k_d = k_wrap ? '0 : k_q + KW'(1);
                j_d = k_wrap ? (j_wrap ? '0 : j_q + NW'(1)) : j_q;
                i_d = j_wrap ? i_q + MW'(1) : i_q;
            end
            DRAIN: begin
                drain_d = 1'b1;
                state_d = drain_q ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy = state_q == ISSUE || state_q == DRAIN;
    assign done = state_q == DONE;
    assign mem_rd_en = state_q == ISSUE;
    assign addr_a_row = i_q;
    assign addr_a_col = k_q;
    assign addr_b_row = k_q;
    assign addr_b_col = j_q;
`ifdef MAC_MULT_SIGNED_EN
    assign product_d = {{DW{data_in_a[DW-1]}}, data_in_a} * {{DW{data_in_b[DW-1]}}, data_in_b};
`else
    assign product_d = {{DW{1'b0}}, data_in_a} * {{DW{1'b0}}, data_in_b};
`endif
    // Tags ride alongside the read so each product carries the addresses that fetched it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
            drain_q <= 1'b0;
            v1_q <= 1'b0;
            ti_q <= '0;
            tj_q <= '0;
            tk_q <= '0;
            mult_done_reg <= 1'b0;
            product_reg <= '0;
            matrix_a_row_addr_counter_reg <= '0;
            matrix_b_col_addr_counter_reg <= '0;
            matrix_a_col_addr_counter_reg <= '0;
            matrix_b_row_addr_counter_reg <= '0;
        end else begin
            state_q <= state_d;
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
            drain_q <= drain_d;
            v1_q <= mem_rd_en;
            mult_done_reg <= v1_q;
            if (mem_rd_en) begin
                ti_q <= i_q;
                tj_q <= j_q;
                tk_q <= k_q;
            end
            if (v1_q) begin
                product_reg <= product_d;
                matrix_a_row_addr_counter_reg <= ti_q;
                matrix_b_col_addr_counter_reg <= tj_q;
                matrix_a_col_addr_counter_reg <= tk_q;
                matrix_b_row_addr_counter_reg <= tk_q;
            end
        end
    end
endmodule

// File: doc/mac_mult_issue.md
# mac_mult_issue

Producer side of the MAC pipeline. Sequences the matrix A and B memories in row/column/k order for a full C = A x B job, multiplies each element pair, and drives one registered product per cycle. Each product is tagged with its four address counters and strobed with mult_done_reg into the accumulate stage (mac_stop_accum), which consumes exactly this interface.

## Interface
- M, 4, rows of A and C
- K, 4, columns of A / rows of B (reduction length)
- N, 4, columns of B and C
- DATA_WIDTH_INIT_MATRIX, 32, element width of A and B

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last product is issued
- mem_rd_en  out  1  read enable to both A and B memories
- addr_a_row  out  clog2(M)  A read row
- addr_a_col  out  clog2(K)  A read column
- addr_b_row  out  clog2(K)  B read row
- addr_b_col  out  clog2(N)  B read column
- data_in_a  in  DATA_WIDTH_INIT_MATRIX  A read data, valid one cycle after mem_rd_en
- data_in_b  in  DATA_WIDTH_INIT_MATRIX  B read data, valid one cycle after mem_rd_en
- product_reg  out  2*DATA_WIDTH_INIT_MATRIX  registered A*B product
- matrix_a_row_addr_counter_reg  out  clog2(M)  i tag of product_reg
- matrix_b_col_addr_counter_reg  out  clog2(N)  j tag of product_reg
- matrix_a_col_addr_counter_reg  out  clog2(K)  k tag of product_reg
- matrix_b_row_addr_counter_reg  out  clog2(K)  k tag of product_reg; always equals matrix_a_col_addr_counter_reg
- mult_done_reg  out  1  product_reg and its tags are valid this cycle

## Operation
- FSM states:
  - IDLE: start -> ISSUE.
  - ISSUE: one (i,j,k) address per cycle with mem_rd_en=1. After (M-1,N-1,K-1) -> DRAIN.
  - DRAIN: 2 cycles, no new reads. Then -> DONE.
  - DONE: done=1 for 1 cycle, then -> IDLE.
- Loop order:
  - k innermost (0..K-1), then j (0..N-1), then i outermost (0..M-1).
  - addr_a = (i,k), addr_b = (k,j).
- Pipeline: stage 1 is the address/read issue. Stage 2 is memory data return, with the tags delayed to match. Stage 3 is product_reg = data_in_a * data_in_b, registered together with its tags and mult_done_reg=1.
- Exactly M*N*K products per job. No gaps and no backpressure, since the consumer accepts one product per cycle.
- Width: the full 2*DATA_WIDTH_INIT_MATRIX product is kept, with no truncation.
- Outputs between valid cycles:
  - product_reg and the tag outputs hold their last value.
  - mult_done_reg=0.
- Addresses hold their last value when mem_rd_en=0.
- start while busy is ignored. start in the same cycle as done is ignored; a new job needs start in IDLE.
- Reset, including mid-job: FSM -> IDLE and all pipeline valid bits cleared. The partial job is abandoned, with no done pulse and no further mult_done_reg.
- Reset values: all outputs 0. This covers busy, done, mem_rd_en, all addresses, product_reg, all tags and mult_done_reg.

## Timing
- start sampled at edge T0 -> busy=1 and first mem_rd_en=1 in cycle T0+1.
- First mult_done_reg=1 in cycle T0+3 with tags (0,0,0).
- Last product in cycle T0+2+M*N*K. With defaults that is T0+66.
- done=1 in cycle T0+3+M*N*K. busy drops in the same cycle that done rises.
- Latency from a read address to its product is 2 cycles.
- Tags in any valid cycle always match the addresses used for that product.

## Configuration
- MAC_MULT_SIGNED_EN defined: A and B data are two's complement, and product_reg is the signed product sign-extended to the full width.
- MAC_MULT_SIGNED_EN undefined: unsigned multiply.
- The macro changes no other behaviour and no timing.

## Test plan
- Ramp job, defaults, A[i][k]=i+1, B[k][j]=k+1, start at T0:
  - mult_done_reg is high continuously T0+3..T0+66.
  - First products are 1,2,3,4 with tags (0,0,k).
  - Product 64 is 16 with tags (3,3,3).
  - done pulses at T0+67.
- Tag order check: over a whole job, tag sequence = k fastest, then j, then i. The two k tags are always equal, and mem_rd_en is asserted for exactly 64 cycles.
- Signed check, A=-3 (0xFFFFFFFD), B=5:
  - With MAC_MULT_SIGNED_EN, product_reg=0xFFFFFFFFFFFFFFF1.
  - Without it, product_reg=0x00000004FFFFFFF1.
- start re-asserted during ISSUE and again in the done cycle -> no effect. Exactly 64 products, then a single done.
- reset asserted at product 20 -> all outputs are 0 asynchronously, and no done follows. A new start then runs a full 64-product job from tags (0,0,0).
- Back-to-back jobs: start in IDLE 1 cycle after done -> the second job has identical timing relative to its own start.
